// File: rtl/psg_array_pkg.sv
// Shared types and constants for the multi-chip PSG block.
package psg_array_pkg;
  typedef enum logic [1:0] {
    PSG_ABC  = 2'd0,
    PSG_ACB  = 2'd1,
    PSG_MONO = 2'd2
  } psg_stereo_mode_t;

  localparam logic [4:0] PSG_SEL_PREFIX = 5'b11111;
endpackage

// File: rtl/psg_array_if.sv
// CPU I/O bus as seen by the PSG block: decoded address, data and strobes.
interface cpu_bus;
  logic [15:0] a_reg;
  logic [7:0]  d_reg;
  logic        ioreq;
  logic        rd;
  logic        wr;

  modport master (output a_reg, d_reg, ioreq, rd, wr);
  modport slave  (input  a_reg, d_reg, ioreq, rd, wr);
endinterface

// File: rtl/psg_array_mix.sv
// Two-stage stereo mixer: per-chip panning into registers, then a registered
// sum across chips.
module psg_stereo_mix
  import psg_array_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int OUT_W     = 10 + $clog2(NUM_CHIPS)
) (
  input  logic                          clk28,
  input  logic                          rst_n,
  input  logic [NUM_CHIPS-1:0][7:0]     i_a,
  input  logic [NUM_CHIPS-1:0][7:0]     i_b,
  input  logic [NUM_CHIPS-1:0][7:0]     i_c,
  input  psg_stereo_mode_t              i_mode,
  input  logic [NUM_CHIPS-1:0]          i_off,
  output logic [OUT_W-1:0]              o_l,
  output logic [OUT_W-1:0]              o_r
);
  logic [NUM_CHIPS-1:0][9:0] w_l1, w_r1, r_l1, r_r1;
  logic [OUT_W-1:0]          w_suml, w_sumr;

  always_comb begin
    w_l1 = '0;
    w_r1 = '0;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      if (!i_off[k]) begin
        case (i_mode)
          PSG_ABC: begin
            w_l1[k] = {2'b0, i_a[k]} + {3'b0, i_b[k][7:1]};
            w_r1[k] = {2'b0, i_c[k]} + {3'b0, i_b[k][7:1]};
          end
          PSG_ACB: begin
            w_l1[k] = {2'b0, i_a[k]} + {3'b0, i_c[k][7:1]};
            w_r1[k] = {2'b0, i_b[k]} + {3'b0, i_c[k][7:1]};
          end
          default: begin
            w_l1[k] = {2'b0, i_a[k]} + {2'b0, i_b[k]} + {2'b0, i_c[k]};
            w_r1[k] = w_l1[k];
          end
        endcase
      end
    end
  end

  always_comb begin
    w_suml = '0;
    w_sumr = '0;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      w_suml = w_suml + OUT_W'(r_l1[k]);
      w_sumr = w_sumr + OUT_W'(r_r1[k]);
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_l1 <= '0;
      r_r1 <= '0;
      o_l  <= '0;
      o_r  <= '0;
    end else begin
      r_l1 <= w_l1;
      r_r1 <= w_r1;
      o_l  <= w_suml;
      o_r  <= w_sumr;
    end
  end
endmodule

// File: rtl/psg_array_ym.sv
// Register-level YM2149 core: address latch, 16-entry register file, and
// channel levels (regs 8..10) sampled into the DAC latches on each PSG clock.
module ym2149 (
  input  logic       clk,
  input  logic       i_ena,
  input  logic       i_rst,
  input  logic       i_addr,
  input  logic       i_we,
  input  logic [7:0] i_da,
  output logic [7:0] o_da,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic [7:0] o_c
);
  logic [7:0] r_regs [16];
  logic [3:0] r_addr;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_addr <= '0;
      o_a    <= '0;
      o_b    <= '0;
      o_c    <= '0;
    end else begin
      if (i_addr) r_addr <= i_da[3:0];
      if (i_we)   r_regs[r_addr] <= i_da;
      if (i_ena) begin
        o_a <= r_regs[8];
        o_b <= r_regs[9];
        o_c <= r_regs[10];
      end
    end
  end

  assign o_da = r_regs[r_addr];
endmodule

// File: rtl/psg_array.sv
// NUM_CHIPS YM2149 cores behind the #FFFD/#BFFD pair with TurboSound-style
// chip select, 1.75 MHz PSG clock generation and a stereo mixer.
module psg_array
  import psg_array_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int OUT_W     = 10 + $clog2(NUM_CHIPS)
) (
  input  logic                 clk28,
  input  logic                 rst_n,
  input  logic                 ck35,
  input  logic                 en,
  input  logic                 en_ts,
  input  logic                 pause,
  input  psg_stereo_mode_t     stereo_mode,
  input  logic [NUM_CHIPS-1:0] mute,
  cpu_bus.slave                bus,
  output logic [7:0]           d_out,
  output logic                 d_out_active,
  output logic [OUT_W-1:0]     snd_l,
  output logic [OUT_W-1:0]     snd_r
);
  logic       w_fffd, w_bffd, w_selwr, w_inc, w_ena, w_busok;
  logic [1:0] w_cand;
  logic       r_bc1, r_bdir, r_selwr;
  logic [1:0] r_sel, r_cnt;
  logic [NUM_CHIPS-1:0]      w_chip_rst, w_addr, w_we, w_off;
  logic [NUM_CHIPS-1:0][7:0] w_a, w_b, w_c, w_da;

  assign w_fffd  = bus.ioreq & bus.a_reg[15] & bus.a_reg[14] & ~bus.a_reg[1];
  assign w_bffd  = bus.ioreq & bus.a_reg[15] & ~bus.a_reg[1];
  assign w_selwr = en & w_fffd & bus.wr & (bus.d_reg[7:3] == PSG_SEL_PREFIX);
  assign w_cand  = 2'd3 - bus.d_reg[1:0];
  assign w_inc   = ck35 & en & ~pause;
  assign w_ena   = r_cnt[1];
  // bc1/bdir stay high one cycle after the I/O cycle ends, so the registered
  // copy keeps a select write away from the address latches on that cycle too.
  assign w_busok = ~(w_selwr | r_selwr);

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_bc1   <= 1'b0;
      r_bdir  <= 1'b0;
      r_selwr <= 1'b0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_bc1   <= en & w_fffd;
      r_bdir  <= en & w_bffd & bus.wr;
      r_selwr <= w_selwr;
      if (!en_ts)
        r_sel <= '0;
      else if (w_selwr && (32'(w_cand) < NUM_CHIPS))
        r_sel <= w_cand;
      if (w_inc) r_cnt    <= r_cnt + 2'd1;
      else       r_cnt[1] <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CHIPS; k++) begin : g_chip
    if (k == 0) begin : g_rst0
      assign w_chip_rst[k] = ~rst_n;
    end else begin : g_rstn
      assign w_chip_rst[k] = ~rst_n | ~en_ts;
    end
    assign w_addr[k] = r_bc1 & r_bdir & (r_sel == 2'(k)) & w_busok;
    assign w_we[k]   = ~r_bc1 & r_bdir & (r_sel == 2'(k)) & w_busok;
    assign w_off[k]  = mute[k] | w_chip_rst[k];

    ym2149 u_ym (
      .clk    (clk28),
      .i_ena  (w_ena),
      .i_rst  (w_chip_rst[k]),
      .i_addr (w_addr[k]),
      .i_we   (w_we[k]),
      .i_da   (bus.d_reg),
      .o_da   (w_da[k]),
      .o_a    (w_a[k]),
      .o_b    (w_b[k]),
      .o_c    (w_c[k])
    );
  end

  always_comb begin
    d_out = '0;
    for (int k = 0; k < NUM_CHIPS; k++)
      if (r_sel == 2'(k)) d_out = w_da[k];
  end

  assign d_out_active = bus.rd & r_bc1 & ~r_bdir;

  psg_stereo_mix #(.NUM_CHIPS(NUM_CHIPS), .OUT_W(OUT_W)) u_mix (
    .clk28  (clk28),
    .rst_n  (rst_n),
    .i_a    (w_a),
    .i_b    (w_b),
    .i_c    (w_c),
    .i_mode (stereo_mode),
    .i_off  (w_off),
    .o_l    (snd_l),
    .o_r    (snd_r)
  );
endmodule

// File: tb/tb_psg_array.sv
// Directed bench for psg_array: a 4-chip and a 2-chip instance on one bus.
module tb_psg_array;
  import psg_array_pkg::*;

  logic clk28 = 1'b0, rst_n = 1'b0, ck35 = 1'b0;
  logic en = 1'b0, en_ts = 1'b0, pause = 1'b0;
  psg_stereo_mode_t stereo_mode = PSG_ABC;
  logic [3:0] mute4 = '0;
  logic [1:0] mute2 = '0;
  logic [7:0]  d4, d2;
  logic        act4, act2;
  logic [11:0] l4, r4;
  logic [10:0] l2, r2;
  int total = 0, bad = 0, ck_cnt = 0, pulses;

  cpu_bus bus ();

  psg_array #(.NUM_CHIPS(4)) u4 (
    .clk28(clk28), .rst_n(rst_n), .ck35(ck35), .en(en), .en_ts(en_ts),
    .pause(pause), .stereo_mode(stereo_mode), .mute(mute4), .bus(bus),
    .d_out(d4), .d_out_active(act4), .snd_l(l4), .snd_r(r4));

  psg_array #(.NUM_CHIPS(2)) u2 (
    .clk28(clk28), .rst_n(rst_n), .ck35(ck35), .en(en), .en_ts(en_ts),
    .pause(pause), .stereo_mode(stereo_mode), .mute(mute2), .bus(bus),
    .d_out(d2), .d_out_active(act2), .snd_l(l2), .snd_r(r2));

  always #5 clk28 = ~clk28;

  // 3.5 MHz strobe: one clk28 cycle in eight
  always @(negedge clk28) begin
    ck_cnt++;
    ck35 = (ck_cnt % 8 == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk28);
    bus.a_reg = a; bus.d_reg = d; bus.ioreq = 1'b1; bus.wr = 1'b1;
    repeat (3) @(negedge clk28);
    bus.ioreq = 1'b0; bus.wr = 1'b0;
    repeat (2) @(negedge clk28);
  endtask

  task automatic io_rd_chk(input string tag, input logic [7:0] exp);
    @(negedge clk28);
    bus.a_reg = 16'hFFFD; bus.ioreq = 1'b1; bus.rd = 1'b1;
    repeat (2) @(negedge clk28);
    chk({tag, "_act"}, 32'(act4), 1);
    chk(tag, 32'(d4), 32'(exp));
    bus.ioreq = 1'b0; bus.rd = 1'b0;
    repeat (2) @(negedge clk28);
  endtask

  task automatic chip_wr(input int k, input logic [7:0] r, input logic [7:0] v);
    io_wr(16'hFFFD, 8'(255 - k));
    io_wr(16'hFFFD, r);
    io_wr(16'hBFFD, v);
  endtask

  task automatic count_ena(input int n);
    pulses = 0;
    repeat (n) begin
      @(negedge clk28);
      if (u4.w_ena) pulses++;
    end
  endtask

  initial begin
    bus.a_reg = '0; bus.d_reg = '0; bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    repeat (3) @(negedge clk28);
    chk("rst_snd_l", 32'(l4), 0);
    chk("rst_snd_r", 32'(r4), 0);
    chk("rst_act", 32'(act4), 0);
    chk("rst_sel", 32'(u4.r_sel), 0);
    rst_n = 1'b1; en = 1'b1; en_ts = 1'b1;
    repeat (2) @(negedge clk28);

    // chip select and per-chip register isolation
    io_wr(16'hFFFD, 8'hFD);
    chk("sel_fd_n4", 32'(u4.r_sel), 2);
    chk("sel_fd_n2", 32'(u2.r_sel), 0);
    io_wr(16'hFFFD, 8'h01);
    io_wr(16'hBFFD, 8'h0F);
    io_rd_chk("rd_chip2", 8'h0F);
    io_wr(16'hFFFD, 8'hFF); io_wr(16'hFFFD, 8'h01); io_rd_chk("rd_chip0", 8'h00);
    io_wr(16'hFFFD, 8'hFE); io_wr(16'hFFFD, 8'h01); io_rd_chk("rd_chip1", 8'h00);
    io_wr(16'hFFFD, 8'hFC); io_wr(16'hFFFD, 8'h01); io_rd_chk("rd_chip3", 8'h00);
    chk("sel_fc_n4", 32'(u4.r_sel), 3);
    io_wr(16'hFFFD, 8'hFB);
    chk("sel_bit2_ign", 32'(u4.r_sel), 0);
    io_wr(16'hFFFD, 8'hFE);
    chk("sel_fe_n2", 32'(u2.r_sel), 1);
    io_wr(16'hFFFD, 8'hFC);
    chk("sel_fc_n2_keep", 32'(u2.r_sel), 1);

    en_ts = 1'b0;
    repeat (2) @(negedge clk28);
    chk("ts_off_sel", 32'(u2.r_sel), 0);
    chk("ts_off_rst1", 32'(u2.w_chip_rst[1]), 1);
    chk("ts_off_rst0", 32'(u2.w_chip_rst[0]), 0);
    en_ts = 1'b1;
    repeat (2) @(negedge clk28);

    // PSG clock: one ENA per 16 clk28
    count_ena(64);
    chk("ena_run", 32'(pulses), 4);
    pause = 1'b1;
    count_ena(64);
    chk("ena_pause", 32'(pulses), 0);
    pause = 1'b0; en = 1'b0;
    count_ena(64);
    chk("ena_dis", 32'(pulses), 0);
    en = 1'b1;

    // mixer, single chip
    chip_wr(0, 8'd8, 8'd255);
    chip_wr(0, 8'd9, 8'd128);
    chip_wr(0, 8'd10, 8'd0);
    repeat (40) @(negedge clk28);
    chk("abc_l", 32'(l4), 319);
    chk("abc_r", 32'(r4), 64);
    stereo_mode = PSG_ACB;
    @(negedge clk28);
    chk("acb_lat1_l", 32'(l4), 319);
    @(negedge clk28);
    chk("acb_l", 32'(l4), 255);
    chk("acb_r", 32'(r4), 128);
    stereo_mode = psg_stereo_mode_t'(2'd3);
    repeat (2) @(negedge clk28);
    chk("mode3_l", 32'(l4), 383);
    chk("mode3_r", 32'(r4), 383);
    stereo_mode = PSG_MONO;

    // pause holds the DAC latches but registers still take writes
    pause = 1'b1;
    chip_wr(0, 8'd8, 8'd17);
    repeat (40) @(negedge clk28);
    chk("pause_hold", 32'(l4), 383);
    io_rd_chk("pause_reg8", 8'd17);
    pause = 1'b0;
    repeat (40) @(negedge clk28);
    chk("unpause", 32'(l4), 145);

    // four chips at full level, then mute
    for (int k = 0; k < 4; k++)
      for (int r = 8; r <= 10; r++)
        chip_wr(k, 8'(r), 8'd255);
    repeat (40) @(negedge clk28);
    chk("mono4_l", 32'(l4), 3060);
    chk("mono4_r", 32'(r4), 3060);
    mute4 = 4'b0101;
    @(negedge clk28);
    chk("mute_lat1", 32'(l4), 3060);
    @(negedge clk28);
    chk("mute_l", 32'(l4), 1530);
    chk("mute_r", 32'(r4), 1530);
    mute4 = '0;
    en_ts = 1'b0;
    repeat (4) @(negedge clk28);
    chk("ts_off_mix", 32'(l4), 765);
    en_ts = 1'b1;
    io_wr(16'hFFFD, 8'hFE);
    chk("sel_pre_rst", 32'(u4.r_sel), 1);

    // async reset in the middle of a read
    bus.a_reg = 16'hFFFD; bus.ioreq = 1'b1; bus.rd = 1'b1;
    repeat (2) @(negedge clk28);
    chk("pre_rst_act", 32'(act4), 1);
    chk("pre_rst_l", 32'(l4), 765);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_act", 32'(act4), 0);
    chk("arst_l", 32'(l4), 0);
    chk("arst_r", 32'(r4), 0);
    chk("arst_sel", 32'(u4.r_sel), 0);
    bus.ioreq = 1'b0; bus.rd = 1'b0;
    repeat (2) @(negedge clk28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
